// File: rtl/rmt_repair_sequencer_pkg.sv
// Shared types and default sizes for the rename-map repair sequencer.
package rmt_repair_sequencer_pkg;

   // Default machine sizes.
   localparam int SIZE_RMT_DEF          = 64;
   localparam int SIZE_RMT_LOG_DEF      = 6;
   localparam int SIZE_PHYSICAL_LOG_DEF = 7;
   localparam int N_REPAIR_PACKETS_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      FLUSH
   } repair_state_t;

endpackage

// File: rtl/rmt_repair_sequencer_if.sv
// Bundle of AMT read port and rename-map repair signals used by the sequencer.
interface rmt_repair_sequencer_if
   import rmt_repair_sequencer_pkg::*;
#(
   parameter int SIZE_RMT_LOG      = SIZE_RMT_LOG_DEF,
   parameter int SIZE_PHYSICAL_LOG = SIZE_PHYSICAL_LOG_DEF,
   parameter int N_REPAIR_PACKETS  = N_REPAIR_PACKETS_DEF
);

   logic                                                recoverFlag_i;
   logic                                                amtRdEn_o;
   logic [N_REPAIR_PACKETS-1:0][SIZE_RMT_LOG-1:0]       amtRdAddr_o;
   logic [N_REPAIR_PACKETS-1:0][SIZE_PHYSICAL_LOG-1:0]  amtRdData_i;
   logic                                                repairFlag_o;
   logic [N_REPAIR_PACKETS-1:0][SIZE_RMT_LOG-1:0]       repairAddr_o;
   logic [N_REPAIR_PACKETS-1:0][SIZE_PHYSICAL_LOG-1:0]  repairData_o;
   logic                                                repairBusy_o;
   logic                                                repairDone_o;

   modport master (
      input  recoverFlag_i, amtRdData_i,
      output amtRdEn_o, amtRdAddr_o, repairFlag_o, repairAddr_o,
             repairData_o, repairBusy_o, repairDone_o
   );

   modport slave (
      output recoverFlag_i, amtRdData_i,
      input  amtRdEn_o, amtRdAddr_o, repairFlag_o, repairAddr_o,
             repairData_o, repairBusy_o, repairDone_o
   );

endinterface

// File: rtl/rmt_repair_sequencer.sv
// Walks the AMT after a recovery and replays it into the rename map table,
// N_REPAIR_PACKETS entries per cycle, holding rename/commit busy meanwhile.
module rmt_repair_sequencer
   import rmt_repair_sequencer_pkg::*;
#(
   parameter int SIZE_RMT          = SIZE_RMT_DEF,
   parameter int SIZE_RMT_LOG      = SIZE_RMT_LOG_DEF,
   parameter int SIZE_PHYSICAL_LOG = SIZE_PHYSICAL_LOG_DEF,
   parameter int N_REPAIR_PACKETS  = N_REPAIR_PACKETS_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   rmt_repair_sequencer_if.master  bus
);

   localparam int              C          = SIZE_RMT / N_REPAIR_PACKETS;
   localparam int              CW         = $clog2(C) + 1;
   localparam logic [CW-1:0]   LAST_CHUNK = CW'(C - 1);

   if (SIZE_RMT % N_REPAIR_PACKETS != 0) begin : g_bad_size
      $error("SIZE_RMT must be a multiple of N_REPAIR_PACKETS");
   end

   repair_state_t            state;
   logic [CW-1:0]            chunk;
   logic                     pkt_valid;
   logic [SIZE_RMT_LOG-1:0]  pkt_base;
   logic [SIZE_RMT_LOG-1:0]  chunk_base;

   assign chunk_base = SIZE_RMT_LOG'(int'(chunk) * N_REPAIR_PACKETS);

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order inside the block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         chunk     <= '0;
         pkt_valid <= 1'b0;
         pkt_base  <= '0;
      end else if (bus.recoverFlag_i) begin
         // A recovery in any state restarts the walk and drops the packet in flight.
         state     <= WALK;
         chunk     <= '0;
         pkt_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pkt_valid <= 1'b0;
            end
            WALK: begin
               pkt_valid <= 1'b1;
               pkt_base  <= chunk_base;
               if (chunk == LAST_CHUNK) state <= FLUSH;
               else                     chunk <= chunk + CW'(1);
            end
            FLUSH: begin
               state     <= IDLE;
               chunk     <= '0;
               pkt_valid <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               chunk     <= '0;
               pkt_valid <= 1'b0;
            end
         endcase
      end
   end

   // AMT data arrives one cycle after its address, aligned with pkt_base.
   always_comb begin
      bus.amtRdEn_o    = (state == WALK);
      bus.repairFlag_o = pkt_valid & ~bus.recoverFlag_i;
      bus.repairBusy_o = (state != IDLE);
      bus.repairDone_o = (state == FLUSH) & ~bus.recoverFlag_i;
      for (int i = 0; i < N_REPAIR_PACKETS; i++) begin
         bus.amtRdAddr_o[i]  = (state == WALK) ? chunk_base + SIZE_RMT_LOG'(i) : '0;
         bus.repairAddr_o[i] = pkt_valid ? pkt_base + SIZE_RMT_LOG'(i) : '0;
         bus.repairData_o[i] = bus.amtRdData_i[i][SIZE_PHYSICAL_LOG-1:0];
      end
   end

endmodule

// File: tb/tb_rmt_repair_sequencer.sv
// Scoreboard bench: recovery stimulus pushes expected packets, a negedge monitor
// pops and compares them against an N=4 and an N=64 (single-chunk) instance.
module tb_rmt_repair_sequencer;

   typedef struct {
      int cyc;
      int base;
      bit last;
   } pkt_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;

   pkt_t q4[$];
   pkt_t q64[$];
   int   bs4, be4, bs64, be64;

   rmt_repair_sequencer_if #(.SIZE_RMT_LOG(6), .SIZE_PHYSICAL_LOG(7), .N_REPAIR_PACKETS(4))  bus4 ();
   rmt_repair_sequencer_if #(.SIZE_RMT_LOG(6), .SIZE_PHYSICAL_LOG(7), .N_REPAIR_PACKETS(64)) bus64 ();

   rmt_repair_sequencer #(
      .SIZE_RMT(64), .SIZE_RMT_LOG(6), .SIZE_PHYSICAL_LOG(7), .N_REPAIR_PACKETS(4)
   ) dut4 (
      .clk(clk), .reset(reset), .bus(bus4)
   );

   rmt_repair_sequencer #(
      .SIZE_RMT(64), .SIZE_RMT_LOG(6), .SIZE_PHYSICAL_LOG(7), .N_REPAIR_PACKETS(64)
   ) dut64 (
      .clk(clk), .reset(reset), .bus(bus64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // AMT model: entry k holds k+64, read data registered one cycle after address.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)  bus4.amtRdData_i[i]  <= 7'(bus4.amtRdAddr_o[i]) + 7'd64;
      for (int i = 0; i < 64; i++) bus64.amtRdData_i[i] <= 7'(bus64.amtRdAddr_o[i]) + 7'd64;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Recovery sampled at the edge closing cycle t: packets t+2..t+C+1, busy t+1..t+C+1.
   task automatic restart4(input int t);
      while (q4.size() > 0 && q4[$].cyc >= t) void'(q4.pop_back());
      if (!(t >= bs4 && t <= be4)) bs4 = t + 1;
      be4 = t + 17;
      for (int k = 0; k < 16; k++) q4.push_back('{t + 2 + k, k * 4, k == 15});
   endtask

   task automatic restart64(input int t);
      while (q64.size() > 0 && q64[$].cyc >= t) void'(q64.pop_back());
      if (!(t >= bs64 && t <= be64)) bs64 = t + 1;
      be64 = t + 2;
      q64.push_back('{t + 2, 0, 1'b1});
   endtask

   task automatic rec4(input int t);
      go_to(t);
      bus4.recoverFlag_i = 1'b1;
      restart4(t);
   endtask

   task automatic idle4(input int t);
      go_to(t);
      bus4.recoverFlag_i = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_flag4"},  32'(bus4.repairFlag_o), 0);
      check({tag, "_busy4"},  32'(bus4.repairBusy_o), 0);
      check({tag, "_done4"},  32'(bus4.repairDone_o), 0);
      check({tag, "_en4"},    32'(bus4.amtRdEn_o), 0);
      check({tag, "_raddr4"}, 32'(bus4.amtRdAddr_o), 0);
      check({tag, "_paddr4"}, 32'(bus4.repairAddr_o), 0);
      check({tag, "_flag64"}, 32'(bus64.repairFlag_o), 0);
      check({tag, "_busy64"}, 32'(bus64.repairBusy_o), 0);
      check({tag, "_en64"},   32'(|bus64.amtRdAddr_o | bus64.amtRdEn_o), 0);
      check({tag, "_paddr64"}, 32'(|bus64.repairAddr_o), 0);
   endtask

   // Monitor: every cycle, compare busy and either the expected packet or silence.
   always @(negedge clk) begin
      pkt_t e;
      check("busy4", 32'(bus4.repairBusy_o), 32'(cyc >= bs4 && cyc <= be4));
      if (q4.size() > 0 && q4[0].cyc == cyc) begin
         e = q4.pop_front();
         check("flag4", 32'(bus4.repairFlag_o), 1);
         check("done4", 32'(bus4.repairDone_o), 32'(e.last));
         for (int i = 0; i < 4; i++) begin
            check("addr4", 32'(bus4.repairAddr_o[i]), 32'(e.base + i));
            check("data4", 32'(bus4.repairData_o[i]), 32'(e.base + i + 64));
         end
      end else begin
         check("noflag4", 32'(bus4.repairFlag_o), 0);
         check("nodone4", 32'(bus4.repairDone_o), 0);
      end

      check("busy64", 32'(bus64.repairBusy_o), 32'(cyc >= bs64 && cyc <= be64));
      if (q64.size() > 0 && q64[0].cyc == cyc) begin
         e = q64.pop_front();
         check("flag64", 32'(bus64.repairFlag_o), 1);
         check("done64", 32'(bus64.repairDone_o), 32'(e.last));
         for (int i = 0; i < 64; i++) begin
            check("addr64", 32'(bus64.repairAddr_o[i]), 32'(e.base + i));
            check("data64", 32'(bus64.repairData_o[i]), 32'(e.base + i + 64));
         end
      end else begin
         check("noflag64", 32'(bus64.repairFlag_o), 0);
         check("nodone64", 32'(bus64.repairDone_o), 0);
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      bs4  = 0;  be4  = -1;
      bs64 = 0;  be64 = -1;
      reset = 1'b0;
      bus4.recoverFlag_i  = 1'b0;
      bus64.recoverFlag_i = 1'b0;
      #1 reset = 1'b1;
      #2 check_quiet("reset");
      go_to(2);
      reset = 1'b0;

      // Basic walk: packets 12..27, done 27, busy 11..27.
      rec4(10);  idle4(11);

      // Mid-walk recovery at 45: no packet at 45/46, restart at 47, done at 62.
      rec4(40);  idle4(41);
      rec4(45);  idle4(46);

      // Recovery coincident with FLUSH at 87: flag/done suppressed, done at 104.
      rec4(70);  idle4(71);
      rec4(87);  idle4(88);

      // Asynchronous reset between edges mid-walk.
      rec4(110); idle4(111);
      go_to(120);
      #2 reset = 1'b1;
      q4.delete();  bs4 = 0;  be4 = -1;
      #1 check_quiet("async_rst");
      go_to(122);
      reset = 1'b0;

      // Recovery held three cycles: single walk, first packet 144, done 159.
      rec4(140);
      rec4(141);
      rec4(142);
      idle4(143);

      // Single-chunk instance: one 64-entry packet at 172, done 172, busy 171..172.
      go_to(170);
      bus64.recoverFlag_i = 1'b1;
      restart64(170);
      go_to(171);
      bus64.recoverFlag_i = 1'b0;

      go_to(180);
      check("q4_drained",  32'(q4.size()), 0);
      check("q64_drained", 32'(q64.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
